// File: rtl/dtree_seq_engine_if.sv
// Bundle of the three handshakes around the decision-tree engine:
//   config port   : cfg_we, cfg_addr, cfg_wdata -> engine; cfg_busy <- engine
//   sample stream : in_valid, in_x -> engine; in_ready <- engine
//   result stream : out_valid, out_class, out_err, out_steps <- engine; out_ready -> engine
// The slave modport is the engine side, the master modport is the system side.
interface dtree_seq_engine_if #(
  parameter int N_FEAT  = 8,
  parameter int FEAT_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int CLASS_W = 6
);
  localparam int FIDX_W  = $clog2(N_FEAT);
  localparam int SHIFT_W = $clog2(FEAT_W);
  localparam int NODE_W  = 1 + FIDX_W + SHIFT_W + FEAT_W + 2 * ADDR_W;

  logic                     cfg_we;
  logic [ADDR_W-1:0]        cfg_addr;
  logic [NODE_W-1:0]        cfg_wdata;
  logic                     cfg_busy;
  logic                     in_valid;
  logic                     in_ready;
  logic [N_FEAT*FEAT_W-1:0] in_x;
  logic                     out_valid;
  logic                     out_ready;
  logic [CLASS_W-1:0]       out_class;
  logic                     out_err;
  logic [ADDR_W:0]          out_steps;

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_x, out_ready,
    output cfg_busy, in_ready, out_valid, out_class, out_err, out_steps
  );

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, in_valid, in_x, out_ready,
    input  cfg_busy, in_ready, out_valid, out_class, out_err, out_steps
  );
endinterface

// File: rtl/dtree_seq_engine.sv
// Sequential decision-tree classifier. A loadable node table is walked one
// node per clock starting at node 0; a leaf ends the walk with its class,
// and a step limit aborts walks that never reach a leaf (cyclic tables).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (node table is not reset)
//   bus   - dtree_seq_engine_if.slave: config, sample and result handshakes
// Node word, MSB to LSB: {is_leaf, feat_idx, shift, thr, left, right}.
module dtree_seq_engine #(
  parameter int N_FEAT  = 8,
  parameter int FEAT_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int CLASS_W = 6
) (
  input logic               clk,
  input logic               rst_n,
  dtree_seq_engine_if.slave bus
);
  localparam int FIDX_W  = $clog2(N_FEAT);
  localparam int SHIFT_W = $clog2(FEAT_W);
  localparam int NODE_W  = 1 + FIDX_W + SHIFT_W + FEAT_W + 2 * ADDR_W;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] STEP_LAST = '1;

  // state | meaning
  // IDLE  | ready for a sample; config writes accepted
  // WALK  | evaluating node[cur] once per clock
  // DONE  | result presented, waiting for out_ready
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t                   state_q, state_d;
  logic [N_FEAT*FEAT_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0]        cur_q, cur_d;
  logic [ADDR_W-1:0]        steps_q, steps_d;
  logic                     out_valid_q, out_valid_d;
  logic [CLASS_W-1:0]       out_class_q, out_class_d;
  logic                     out_err_q, out_err_d;
  logic [ADDR_W:0]          out_steps_q, out_steps_d;

  logic [NODE_W-1:0] node_mem [DEPTH];

  // Table has no reset so a loaded model survives rst_n.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.cfg_we) node_mem[bus.cfg_addr] <= bus.cfg_wdata;
  end

  logic [NODE_W-1:0]  node;
  logic               n_leaf;
  logic [FIDX_W-1:0]  n_fidx;
  logic [SHIFT_W-1:0] n_shift;
  logic [FEAT_W-1:0]  n_thr;
  logic [ADDR_W-1:0]  n_left, n_right;
  logic [FEAT_W-1:0]  feat, feat_v;

  assign node = node_mem[cur_q];
  assign {n_leaf, n_fidx, n_shift, n_thr, n_left, n_right} = node;

  // Feature indices beyond N_FEAT select nothing and read as zero.
  always_comb begin
    feat = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (n_fidx == FIDX_W'(i)) feat = x_q[i*FEAT_W +: FEAT_W];
    end
    feat_v = feat >> n_shift;
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    cur_d       = cur_q;
    steps_d     = steps_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_err_d   = out_err_q;
    out_steps_d = out_steps_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.in_x;
          cur_d   = '0;
          steps_d = '0;
          state_d = WALK;
        end
      end
      WALK: begin
        if (n_leaf) begin
          out_class_d = n_thr[CLASS_W-1:0];
          out_err_d   = 1'b0;
          out_steps_d = {1'b0, steps_q} + 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (steps_q == STEP_LAST) begin
          out_class_d = '0;
          out_err_d   = 1'b1;
          out_steps_d = (ADDR_W+1)'(DEPTH);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cur_d   = (feat_v <= n_thr) ? n_left : n_right;
          steps_d = steps_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      cur_q       <= '0;
      steps_q     <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_err_q   <= 1'b0;
      out_steps_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      cur_q       <= cur_d;
      steps_q     <= steps_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_err_q   <= out_err_d;
      out_steps_q <= out_steps_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.cfg_busy  = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_class = out_class_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_steps = out_steps_q;
endmodule

// File: tb/tb_dtree_seq_engine.sv
module tb_dtree_seq_engine;
  localparam int N_FEAT = 8, FEAT_W = 8, ADDR_W = 6, CLASS_W = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dtree_seq_engine_if #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .ADDR_W(ADDR_W), .CLASS_W(CLASS_W)) bus_if ();

  dtree_seq_engine #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .ADDR_W(ADDR_W), .CLASS_W(CLASS_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference tree, kept as plain per-field arrays.
  int m_leaf [DEPTH];
  int m_fidx [DEPTH];
  int m_sh   [DEPTH];
  int m_thr  [DEPTH];
  int m_left [DEPTH];
  int m_right[DEPTH];

  typedef struct {
    int    x6;
    int    cls;
    int    steps;
    string nm;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Walk the reference tree: visit up to DEPTH nodes, abort if no leaf found.
  task automatic model(input logic [63:0] x, output int cls, output int err, output int steps);
    int cur = 0;
    cls = 0; err = 1; steps = DEPTH;
    for (int n = 1; n <= DEPTH; n++) begin
      if (m_leaf[cur] != 0) begin
        cls = m_thr[cur] % 64; err = 0; steps = n;
        return;
      end else begin
        int f, v;
        f = (m_fidx[cur] < N_FEAT) ? int'(x[m_fidx[cur]*8 +: 8]) : 0;
        v = f / (1 << m_sh[cur]);
        cur = (v <= m_thr[cur]) ? m_left[cur] : m_right[cur];
      end
    end
  endtask

  task automatic cfg_write(input int a, input int leaf, input int fidx, input int sh,
                           input int thr, input int l, input int r, input bit upd);
    @(negedge clk);
    bus_if.cfg_we    = 1'b1;
    bus_if.cfg_addr  = 6'(a);
    bus_if.cfg_wdata = {1'(leaf), 3'(fidx), 3'(sh), 8'(thr), 6'(l), 6'(r)};
    @(negedge clk);
    bus_if.cfg_we = 1'b0;
    if (upd) begin
      m_leaf[a] = leaf; m_fidx[a] = fidx; m_sh[a] = sh;
      m_thr[a] = thr; m_left[a] = l; m_right[a] = r;
    end
  endtask

  function automatic logic [63:0] x_of(input int x6);
    logic [63:0] x = '0;
    x[6*8 +: 8] = 8'(x6);
    return x;
  endfunction

  task automatic accept(input logic [63:0] x);
    @(negedge clk);
    chk("in_ready_before_accept", bus_if.in_ready, 1);
    bus_if.in_valid = 1'b1;
    bus_if.in_x     = x;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; lat counts edges since accept.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus_if.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!bus_if.out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic handshake();
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    chk("out_valid_after_hs", bus_if.out_valid, 0);
    chk("in_ready_after_hs", bus_if.in_ready, 1);
  endtask

  task automatic run_sample(input logic [63:0] x, input string nm);
    int cls, err, steps, lat;
    model(x, cls, err, steps);
    accept(x);
    wait_result(lat);
    chk({nm, "_class"}, bus_if.out_class, cls);
    chk({nm, "_err"}, bus_if.out_err, err);
    chk({nm, "_steps"}, bus_if.out_steps, steps);
    chk({nm, "_latency"}, lat, steps);
    handshake();
  endtask

  task automatic load_small_tree();
    cfg_write(0, 0, 6, 3, 15, 1, 2, 1);
    cfg_write(1, 1, 0, 0, 43, 0, 0, 1);
    cfg_write(2, 1, 0, 0, 44, 0, 0, 1);
  endtask

  initial begin
    int lat;
    vecs[0] = '{x6: 'h78, cls: 43, steps: 2, nm: "v78"};
    vecs[1] = '{x6: 'h80, cls: 44, steps: 2, nm: "v80"};
    vecs[2] = '{x6: 'h00, cls: 43, steps: 2, nm: "v00"};
    vecs[3] = '{x6: 'hFF, cls: 44, steps: 2, nm: "vFF"};
    vecs[4] = '{x6: 'h7F, cls: 43, steps: 2, nm: "v7F"};

    bus_if.cfg_we = 0; bus_if.cfg_addr = '0; bus_if.cfg_wdata = '0;
    bus_if.in_valid = 0; bus_if.in_x = '0; bus_if.out_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_leaf[i] = 1; m_fidx[i] = 0; m_sh[i] = 0; m_thr[i] = 0; m_left[i] = 0; m_right[i] = 0;
    end

    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus_if.in_ready, 1);
    chk("rst_cfg_busy", bus_if.cfg_busy, 0);
    chk("rst_out_valid", bus_if.out_valid, 0);
    chk("rst_out_class", bus_if.out_class, 0);
    chk("rst_out_err", bus_if.out_err, 0);
    chk("rst_out_steps", bus_if.out_steps, 0);
    rst_n = 1'b1;

    load_small_tree();
    foreach (vecs[i]) begin
      accept(x_of(vecs[i].x6));
      wait_result(lat);
      chk({vecs[i].nm, "_class"}, bus_if.out_class, vecs[i].cls);
      chk({vecs[i].nm, "_steps"}, bus_if.out_steps, vecs[i].steps);
      chk({vecs[i].nm, "_err"}, bus_if.out_err, 0);
      chk({vecs[i].nm, "_latency"}, lat, vecs[i].steps);
      handshake();
    end

    // Backpressure: result held, new sample waits for the handshake.
    accept(x_of('h78));
    wait_result(lat);
    bus_if.in_valid = 1'b1;
    bus_if.in_x = x_of('h80);
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", bus_if.out_valid, 1);
      chk("bp_out_class", bus_if.out_class, 43);
      chk("bp_out_steps", bus_if.out_steps, 2);
      chk("bp_in_ready", bus_if.in_ready, 0);
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    chk("bp_hs_in_ready", bus_if.in_ready, 1);
    chk("bp_hs_out_valid", bus_if.out_valid, 0);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    chk("bp_second_accepted", bus_if.in_ready, 0);
    wait_result(lat);
    chk("bp_second_class", bus_if.out_class, 44);
    chk("bp_second_latency", lat, 2);
    handshake();

    // Config write during WALK is dropped.
    accept(x_of('h78));
    chk("busy_during_walk", bus_if.cfg_busy, 1);
    bus_if.cfg_we = 1'b1;
    bus_if.cfg_addr = 6'd1;
    bus_if.cfg_wdata = {1'b1, 3'd0, 3'd0, 8'd7, 6'd0, 6'd0};
    @(negedge clk);
    bus_if.cfg_we = 1'b0;
    wait_result(lat);
    chk("busy_wr_class", bus_if.out_class, 43);
    handshake();
    run_sample(x_of('h78), "after_busy_wr");
    cfg_write(1, 1, 0, 0, 7, 0, 0, 1);
    run_sample(x_of('h78), "idle_wr");
    cfg_write(1, 1, 0, 0, 43, 0, 0, 1);

    // Reset mid-walk: outputs clear at once, table survives.
    accept(x_of('h78));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus_if.out_valid, 0);
    chk("midrst_in_ready", bus_if.in_ready, 1);
    chk("midrst_cfg_busy", bus_if.cfg_busy, 0);
    chk("midrst_out_steps", bus_if.out_steps, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sample(x_of('h78), "post_rst");

    // Root leaf and cyclic table.
    cfg_write(0, 1, 0, 0, 5, 0, 0, 1);
    run_sample(x_of('h11), "root_leaf");
    cfg_write(0, 0, 0, 0, 0, 0, 0, 1);
    run_sample(x_of('h11), "cyclic");

    // Random tables against the reference walk.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < DEPTH; i++)
        cfg_write(i, ($urandom_range(0, 2) == 0) ? 1 : 0, $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 255),
                  $urandom_range(0, 63), $urandom_range(0, 63), 1);
      for (int s = 0; s < 20; s++)
        run_sample({$urandom, $urandom}, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
